// File: rtl/marquee_pkg.sv
// rtl/marquee_pkg.sv - shared state encoding and default sizing for the marquee sequence loader
package marquee_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PAUSE = 2'd1,
        ENTRY = 2'd2
    } ld_state_t;

    localparam int N_DEF     = 32;
    localparam int WIDTH_DEF = 4;
    localparam int DIGITS    = N_DEF / WIDTH_DEF;
    localparam int CNT_W     = $clog2(DIGITS) + 1;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-FF synchroniser, stability counter and rising-edge press pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic raw_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    // The counter only runs while the synchronised level disagrees with the accepted
    // level; any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            pulse_q <= 1'b0;
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_q <= sync2_q;
                pulse_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/marquee_seq_loader.sv
// rtl/marquee_seq_loader.sv - digit entry FSM feeding the marquee seq/enable inputs
module marquee_seq_loader
    import marquee_pkg::*;
#(
    parameter int           N          = 32,
    parameter int           WIDTH      = 4,
    parameter int           DEB_CYCLES = 1_000_000,
    parameter logic [N-1:0] INIT_SEQ   = 32'h0123_4567
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic [WIDTH-1:0]           digit_in,
    input  logic                       btn_push,
    input  logic                       btn_clear,
    input  logic                       btn_run,
    output logic [N-1:0]               seq,
    output logic                       enable,
    output logic                       entry_mode,
    output logic [$clog2(N/WIDTH):0]   digit_cnt
);

    localparam int DIGITS_L = N / WIDTH;
    localparam int CW       = $clog2(DIGITS_L) + 1;

    logic push_pulse, clear_pulse, run_pulse;
    logic [WIDTH-1:0] digit_s1_q, digit_s2_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_push (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .raw_i(btn_push),
        .level_o(), .pulse_o(push_pulse)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clear (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .raw_i(btn_clear),
        .level_o(), .pulse_o(clear_pulse)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .raw_i(btn_run),
        .level_o(), .pulse_o(run_pulse)
    );

    ld_state_t         state_q, state_d;
    logic [N-1:0]      stage_q, stage_d;
    logic [N-1:0]      committed_q, committed_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N-1:0]      seq_q, seq_d;
    logic              enable_q, enable_d;
    logic              entry_q, entry_d;

    logic [N-1:0]      base_stage, pushed_stage;
    logic [CW-1:0]     base_cnt, pushed_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            digit_s1_q  <= '0;
            digit_s2_q  <= '0;
            state_q     <= RUN;
            stage_q     <= '0;
            committed_q <= INIT_SEQ;
            cnt_q       <= '0;
            seq_q       <= INIT_SEQ;
            enable_q    <= 1'b1;
            entry_q     <= 1'b0;
        end else begin
            digit_s1_q  <= digit_in;
            digit_s2_q  <= digit_s1_q;
            state_q     <= state_d;
            stage_q     <= stage_d;
            committed_q <= committed_d;
            cnt_q       <= cnt_d;
            seq_q       <= seq_d;
            enable_q    <= enable_d;
            entry_q     <= entry_d;
        end
    end

    // A push from RUN/PAUSE behaves like a push into an empty stage, so one path
    // handles both the first digit and the full-stage auto-commit.
    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        committed_d  = committed_q;
        cnt_d        = cnt_q;
        base_stage   = (state_q == ENTRY) ? stage_q : '0;
        base_cnt     = (state_q == ENTRY) ? cnt_q : '0;
        pushed_stage = {base_stage[N-WIDTH-1:0], digit_s2_q};
        pushed_cnt   = base_cnt + 1'b1;

        if (clear_pulse) begin
            if (state_q == ENTRY) begin
                stage_d = '0;
                cnt_d   = '0;
            end else begin
                committed_d = INIT_SEQ;
            end
        end else if (run_pulse) begin
            case (state_q)
                RUN:   state_d = PAUSE;
                PAUSE: state_d = RUN;
                default: begin
                    if (cnt_q != '0) begin
                        committed_d = stage_q;
                    end
                    cnt_d   = '0;
                    state_d = RUN;
                end
            endcase
        end else if (push_pulse) begin
            stage_d = pushed_stage;
            if (pushed_cnt == CW'(DIGITS_L)) begin
                committed_d = pushed_stage;
                cnt_d       = '0;
                state_d     = RUN;
            end else begin
                cnt_d   = pushed_cnt;
                state_d = ENTRY;
            end
        end

        seq_d    = (state_d == ENTRY) ? stage_d : committed_d;
        enable_d = (state_d == RUN);
        entry_d  = (state_d == ENTRY);
    end

    assign seq        = seq_q;
    assign enable     = enable_q;
    assign entry_mode = entry_q;
    assign digit_cnt  = cnt_q;

endmodule

// File: tb/tb_marquee_seq_loader.sv
// tb/tb_marquee_seq_loader.sv - scoreboard bench for the marquee sequence loader
module tb_marquee_seq_loader;

    typedef struct packed {
        logic [31:0] seq;
        logic        en;
        logic        entry;
        logic [3:0]  cnt;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  digit_in = 4'h0;
    logic        btn_push = 1'b0;
    logic        btn_clear = 1'b0;
    logic        btn_run = 1'b0;
    logic [31:0] seq;
    logic        enable;
    logic        entry_mode;
    logic [3:0]  digit_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t exp_v;
    exp_t obs;

    marquee_seq_loader #(
        .N(32), .WIDTH(4), .DEB_CYCLES(4), .INIT_SEQ(32'h0123_4567)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .digit_in(digit_in),
        .btn_push(btn_push), .btn_clear(btn_clear), .btn_run(btn_run),
        .seq(seq), .enable(enable), .entry_mode(entry_mode), .digit_cnt(digit_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic press(input logic p, input logic c, input logic r, input logic [3:0] d);
        @(negedge sys_clk);
        digit_in = d;
        repeat (3) @(negedge sys_clk);
        btn_push  = p;
        btn_clear = c;
        btn_run   = r;
        repeat (12) @(negedge sys_clk);
        btn_push  = 1'b0;
        btn_clear = 1'b0;
        btn_run   = 1'b0;
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        sb.push_back('{32'h0123_4567, 1'b1, 1'b0, 4'd0});
        @(negedge sys_clk);
        exp_v = sb.pop_front();
        obs = {seq, enable, entry_mode, digit_cnt};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset: seq=%h en=%b entry=%b cnt=%0d required seq=%h en=%b entry=%b cnt=%0d",
                     obs.seq, obs.en, obs.entry, obs.cnt, exp_v.seq, exp_v.en, exp_v.entry, exp_v.cnt);
        end
    endtask

    task automatic test_digit_entry();
        logic [31:0] preview = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            preview = {preview[27:0], 4'(k)};
            if (k < 8) sb.push_back('{preview, 1'b0, 1'b1, 4'(k)});
            else       sb.push_back('{32'h1234_5678, 1'b1, 1'b0, 4'd0});
            press(1'b1, 1'b0, 1'b0, 4'(k));
            exp_v = sb.pop_front();
            obs = {seq, enable, entry_mode, digit_cnt};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL entry_step%0d: seq=%h en=%b entry=%b cnt=%0d required seq=%h en=%b entry=%b cnt=%0d",
                         k, obs.seq, obs.en, obs.entry, obs.cnt, exp_v.seq, exp_v.en, exp_v.entry, exp_v.cnt);
            end
        end
    endtask

    task automatic test_run_commit();
        exp_t steps[4] = '{'{32'h0000_000A, 1'b0, 1'b1, 4'd1},
                           '{32'h0000_00AB, 1'b0, 1'b1, 4'd2},
                           '{32'h0000_00AB, 1'b1, 1'b0, 4'd0},
                           '{32'h0000_00AB, 1'b0, 1'b0, 4'd0}};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(steps[i]);
            case (i)
                0: press(1'b1, 1'b0, 1'b0, 4'hA);
                1: press(1'b1, 1'b0, 1'b0, 4'hB);
                default: press(1'b0, 1'b0, 1'b1, 4'h0);
            endcase
            exp_v = sb.pop_front();
            obs = {seq, enable, entry_mode, digit_cnt};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL run_commit%0d: seq=%h en=%b entry=%b cnt=%0d required seq=%h en=%b entry=%b cnt=%0d",
                         i, obs.seq, obs.en, obs.entry, obs.cnt, exp_v.seq, exp_v.en, exp_v.entry, exp_v.cnt);
            end
        end
    endtask

    task automatic test_bounce();
        sb.push_back('{32'h0000_0003, 1'b0, 1'b1, 4'd1});
        sb.push_back('{32'h0000_0003, 1'b0, 1'b1, 4'd1});
        @(negedge sys_clk);
        digit_in = 4'h3;
        repeat (3) @(negedge sys_clk);
        btn_push = 1'b1;
        @(negedge sys_clk);
        btn_push = 1'b0;
        @(negedge sys_clk);
        btn_push = 1'b1;
        repeat (14) @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            exp_v = sb.pop_front();
            obs = {seq, enable, entry_mode, digit_cnt};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL bounce_%s: seq=%h en=%b entry=%b cnt=%0d required seq=%h en=%b entry=%b cnt=%0d",
                         (i == 0) ? "held" : "released",
                         obs.seq, obs.en, obs.entry, obs.cnt, exp_v.seq, exp_v.en, exp_v.entry, exp_v.cnt);
            end
            if (i == 0) begin
                btn_push = 1'b0;
                repeat (12) @(negedge sys_clk);
            end
        end
    endtask

    task automatic test_clear_run_priority();
        exp_t steps[4] = '{'{32'h0000_0034, 1'b0, 1'b1, 4'd2},
                           '{32'h0000_0345, 1'b0, 1'b1, 4'd3},
                           '{32'h0000_0000, 1'b0, 1'b1, 4'd0},
                           '{32'h0000_00AB, 1'b1, 1'b0, 4'd0}};
        for (int i = 0; i < 4; i++) begin
            sb.push_back(steps[i]);
            case (i)
                0: press(1'b1, 1'b0, 1'b0, 4'h4);
                1: press(1'b1, 1'b0, 1'b0, 4'h5);
                2: press(1'b0, 1'b1, 1'b1, 4'h0);
                default: press(1'b0, 1'b0, 1'b1, 4'h0);
            endcase
            exp_v = sb.pop_front();
            obs = {seq, enable, entry_mode, digit_cnt};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL clear_run%0d: seq=%h en=%b entry=%b cnt=%0d required seq=%h en=%b entry=%b cnt=%0d",
                         i, obs.seq, obs.en, obs.entry, obs.cnt, exp_v.seq, exp_v.en, exp_v.entry, exp_v.cnt);
            end
        end
    endtask

    task automatic test_reset_mid_entry();
        for (int k = 1; k <= 5; k++) press(1'b1, 1'b0, 1'b0, 4'(k));
        sb.push_back('{32'h0001_2345, 1'b0, 1'b1, 4'd5});
        sb.push_back('{32'h0123_4567, 1'b1, 1'b0, 4'd0});
        sb.push_back('{32'h0000_0009, 1'b0, 1'b1, 4'd1});
        sb.push_back('{32'h0000_0000, 1'b0, 1'b1, 4'd0});
        sb.push_back('{32'h0123_4567, 1'b1, 1'b0, 4'd0});
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: ;
                1: begin
                    sys_rst = 1'b1;
                    @(negedge sys_clk);
                    sys_rst = 1'b0;
                end
                2: press(1'b1, 1'b0, 1'b0, 4'h9);
                3: press(1'b0, 1'b1, 1'b0, 4'h0);
                default: press(1'b0, 1'b0, 1'b1, 4'h0);
            endcase
            exp_v = sb.pop_front();
            obs = {seq, enable, entry_mode, digit_cnt};
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_abort%0d: seq=%h en=%b entry=%b cnt=%0d required seq=%h en=%b entry=%b cnt=%0d",
                         i, obs.seq, obs.en, obs.entry, obs.cnt, exp_v.seq, exp_v.en, exp_v.entry, exp_v.cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_digit_entry();
        test_run_commit();
        test_bounce();
        test_clear_run_priority();
        test_reset_mid_entry();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: left=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: time=%0t required=finish before 2000000", $time);
        $fatal(1, "timeout");
    end

endmodule
